// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_pkg
// Description : Shared constants for the two-requester ALU sharing arbiter:
//               ALU opcode encodings, command flag bundle layout and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

    // ALU opcodes. The arbiter never interprets them except for the
    // optional invalid-opcode precheck.
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;
    localparam logic [2:0] OP_INV6  = 3'd6;
    localparam logic [2:0] OP_INV7  = 3'd7;

    // Flag bundle {cin, red_op_A, red_op_B, bypass_A, bypass_B}, MSB first.
    localparam int FLAGS_W    = 5;
    localparam int FLAG_CIN   = 4;
    localparam int FLAG_RED_A = 3;
    localparam int FLAG_RED_B = 2;
    localparam int FLAG_BYP_A = 1;
    localparam int FLAG_BYP_B = 0;

    // Arbiter state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // True for the two opcodes the ALU reports as invalid.
    function automatic logic is_invalid_op(input logic [2:0] op);
        return (op == OP_INV6) || (op == OP_INV7);
    endfunction

endpackage : alu_share_pkg
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. When both requests are active
//               the requester that did not win last time is granted. The
//               pointer only moves when the caller reports that the grant
//               was actually used (advance), so a requester that withdraws
//               before being served loses nothing.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (pointer -> 1, so
//                         requester 0 wins the first tie)
//               req     - request vector, bit N = requester N
//               advance - grant consumed this cycle; record the winner
//               grant   - one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (advance) begin
            r_last_grant <= grant[1];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one combinational ALU between two requesters.
//               A round-robin arbiter picks a command (valid/ready), the
//               operands/opcode/flags are registered onto the ALU inputs,
//               the ALU settles for one cycle and its result is captured
//               into a single response channel tagged with the requester id.
//               Sequence: IDLE -> EXEC -> RESP -> IDLE (one command per
//               three cycles at best; no accept while a response is held).
// Options     : ALU_SHARE_ARBITER_PRECHECK_EN - when defined, opcodes 6/7
//               skip EXEC and answer directly with rsp_invalid=1, data 0,
//               parity 0, leaving the ALU input registers untouched.
// Ports       : clk, rst             - clock / synchronous active-high reset
//               reqN_valid/ready     - command handshake, requester N
//               reqN_a/b/opcode/flags- command payload, requester N
//               alu_*  (out)         - registered ALU operands and flags
//               alu_out/odd_parity/invalid (in) - ALU result
//               rsp_valid/ready      - response handshake
//               rsp_id/data/odd_parity/invalid - captured response
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    // requester 0
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BITS-1:0]    req0_a,
    input  logic [BITS-1:0]    req0_b,
    input  logic [2:0]         req0_opcode,
    input  logic [FLAGS_W-1:0] req0_flags,
    // requester 1
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [BITS-1:0]    req1_a,
    input  logic [BITS-1:0]    req1_b,
    input  logic [2:0]         req1_opcode,
    input  logic [FLAGS_W-1:0] req1_flags,
    // ALU interface
    output logic [BITS-1:0]    alu_a,
    output logic [BITS-1:0]    alu_b,
    output logic [2:0]         alu_opcode,
    output logic               alu_cin,
    output logic               alu_red_op_a,
    output logic               alu_red_op_b,
    output logic               alu_bypass_a,
    output logic               alu_bypass_b,
    input  logic [BITS:0]      alu_out,
    input  logic               alu_odd_parity,
    input  logic               alu_invalid,
    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [BITS:0]      rsp_data,
    output logic               rsp_odd_parity,
    output logic               rsp_invalid
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [1:0]         w_req;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_sel;
    logic               w_skip;

    logic [BITS-1:0]    w_sel_a;
    logic [BITS-1:0]    w_sel_b;
    logic [2:0]         w_sel_op;
    logic [FLAGS_W-1:0] w_sel_flags;

    logic [BITS-1:0]    r_alu_a;
    logic [BITS-1:0]    r_alu_b;
    logic [2:0]         r_alu_op;
    logic [FLAGS_W-1:0] r_alu_flags;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [BITS:0]      r_rsp_data;
    logic               r_rsp_par;
    logic               r_rsp_inv;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_accept),
        .grant   (w_grant)
    );

    // Grant implies valid, so a raised ready is always a handshake.
    assign w_accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_sel    = w_grant[1];

    assign w_sel_a     = w_sel ? req1_a      : req0_a;
    assign w_sel_b     = w_sel ? req1_b      : req0_b;
    assign w_sel_op    = w_sel ? req1_opcode : req0_opcode;
    assign w_sel_flags = w_sel ? req1_flags  : req0_flags;

`ifdef ALU_SHARE_ARBITER_PRECHECK_EN
    // Known-invalid opcodes are answered without touching the ALU.
    assign w_skip = w_accept & is_invalid_op(w_sel_op);
`else
    assign w_skip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_skip ? RESP : EXEC;
                end
            end
            EXEC: w_next_state = RESP;
            RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Ready is masked during reset so nothing is accepted
    // on the edge that clears the block.
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((r_state == IDLE) && !rst) begin
            req0_ready = w_grant[0];
            req1_ready = w_grant[1];
        end
    end

    // ------------------------------------------------------------------
    // Datapath: ALU input registers and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_flags <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_par   <= 1'b0;
            r_rsp_inv   <= 1'b0;
        end else begin
            // ALU inputs hold their last command between transactions.
            if (w_accept && !w_skip) begin
                r_alu_a     <= w_sel_a;
                r_alu_b     <= w_sel_b;
                r_alu_op    <= w_sel_op;
                r_alu_flags <= w_sel_flags;
            end
            if (w_accept) begin
                r_rsp_id <= w_sel;
            end

            if (r_state == EXEC) begin
                r_rsp_data  <= alu_out;
                r_rsp_par   <= alu_odd_parity;
                r_rsp_inv   <= alu_invalid;
                r_rsp_valid <= 1'b1;
            end else if (w_skip) begin
                r_rsp_data  <= '0;
                r_rsp_par   <= 1'b0;
                r_rsp_inv   <= 1'b1;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_op;
    assign alu_cin      = r_alu_flags[FLAG_CIN];
    assign alu_red_op_a = r_alu_flags[FLAG_RED_A];
    assign alu_red_op_b = r_alu_flags[FLAG_RED_B];
    assign alu_bypass_a = r_alu_flags[FLAG_BYP_A];
    assign alu_bypass_b = r_alu_flags[FLAG_BYP_B];

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_data       = r_rsp_data;
    assign rsp_odd_parity = r_rsp_par;
    assign rsp_invalid    = r_rsp_inv;

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter. A behavioural ALU
//               answers the DUT's ALU port; a cycle model predicts handshakes
//               and pushes expected responses to a scoreboard queue that is
//               compared whenever the DUT presents a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int BITS = 4;
    localparam int OW   = BITS + 1;

    typedef struct packed {
        logic          id;
        logic [OW-1:0] data;
        logic          par;
        logic          inv;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0_valid = 1'b0, req1_valid = 1'b0;
    logic               req0_ready, req1_ready;
    logic [BITS-1:0]    req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]         req0_opcode = '0, req1_opcode = '0;
    logic [FLAGS_W-1:0] req0_flags = '0, req1_flags = '0;
    logic [BITS-1:0]    alu_a, alu_b;
    logic [2:0]         alu_opcode;
    logic               alu_cin, alu_red_op_a, alu_red_op_b, alu_bypass_a, alu_bypass_b;
    logic [OW-1:0]      alu_out;
    logic               alu_odd_parity, alu_invalid;
    logic               rsp_valid, rsp_id, rsp_odd_parity, rsp_invalid;
    logic               rsp_ready = 1'b1;
    logic [OW-1:0]      rsp_data;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   grant_log[$];
    logic [1:0] m_state = IDLE;
    logic       m_last  = 1'b1;
    bit         mon_en  = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opcode(req0_opcode), .req0_flags(req0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opcode(req1_opcode), .req1_flags(req1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_red_op_a(alu_red_op_a), .alu_red_op_b(alu_red_op_b),
        .alu_bypass_a(alu_bypass_a), .alu_bypass_b(alu_bypass_b),
        .alu_out(alu_out), .alu_odd_parity(alu_odd_parity), .alu_invalid(alu_invalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_odd_parity(rsp_odd_parity), .rsp_invalid(rsp_invalid)
    );

    // Behavioural ALU: returns {invalid, odd_parity, out}.
    function automatic logic [OW+1:0] alu_model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                                input logic [2:0] op, input logic [FLAGS_W-1:0] fl);
        logic [BITS-1:0]   aa, bb;
        logic [2*BITS-1:0] p;
        logic [OW-1:0]     o;
        logic              inv;
        aa  = fl[FLAG_RED_A] ? {{(BITS-1){1'b0}}, ^a} : a;
        bb  = fl[FLAG_RED_B] ? {{(BITS-1){1'b0}}, ^b} : b;
        p   = aa * bb;
        o   = '0;
        inv = 1'b0;
        case (op)
            3'd0: o = {1'b0, aa & bb};
            3'd1: o = {1'b0, aa ^ bb};
            3'd2: o = {1'b0, aa} + {1'b0, bb} + OW'(fl[FLAG_CIN]);
            3'd3: o = p[OW-1:0];
            3'd4: o = {aa, 1'b0};
            3'd5: o = {1'b0, aa[BITS-2:0], aa[BITS-1]};
            default: inv = 1'b1;
        endcase
        if (!inv && fl[FLAG_BYP_A])      o = {1'b0, a};
        else if (!inv && fl[FLAG_BYP_B]) o = {1'b0, b};
        return {inv, ^o, o};
    endfunction

    logic [OW+1:0] w_alu_res;
    assign w_alu_res      = alu_model(alu_a, alu_b, alu_opcode,
                                      {alu_cin, alu_red_op_a, alu_red_op_b, alu_bypass_a, alu_bypass_b});
    assign alu_out        = w_alu_res[OW-1:0];
    assign alu_odd_parity = w_alu_res[OW];
    assign alu_invalid    = w_alu_res[OW+1];

    function automatic exp_t exp_rsp(input logic id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                     input logic [2:0] op, input logic [FLAGS_W-1:0] fl);
        exp_t          e;
        logic [OW+1:0] r;
        r      = alu_model(a, b, op, fl);
        e.id   = id;
        e.data = r[OW-1:0];
        e.par  = r[OW];
        e.inv  = r[OW+1];
`ifdef ALU_SHARE_ARBITER_PRECHECK_EN
        if (op[2:1] == 2'b11) begin
            e.data = '0;
            e.par  = 1'b0;
            e.inv  = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Cycle model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin : monitor
        logic g0, g1;
        exp_t e;
        if (mon_en) begin
            if (req0_valid && req0_ready) grant_log.push_back(0);
            if (req1_valid && req1_ready) grant_log.push_back(1);
            g0 = 1'b0;
            g1 = 1'b0;
            if (m_state == IDLE && !rst) begin
                if (req0_valid && req1_valid) begin
                    g0 = m_last;
                    g1 = !m_last;
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            check("ready0", req0_ready, g0);
            check("ready1", req1_ready, g1);
            check("rsp_valid", rsp_valid, (m_state == RESP));
            if (m_state == RESP) begin
                check("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_parity", rsp_odd_parity, e.par);
                    check("rsp_invalid", rsp_invalid, e.inv);
                end
            end
            if (rst) begin
                m_state = IDLE;
                m_last  = 1'b1;
                sb.delete();
            end else begin
                case (m_state)
                    IDLE: if (g0 || g1) begin
                        e = g1 ? exp_rsp(1'b1, req1_a, req1_b, req1_opcode, req1_flags)
                               : exp_rsp(1'b0, req0_a, req0_b, req0_opcode, req0_flags);
                        sb.push_back(e);
                        m_last  = g1;
                        m_state = EXEC;
`ifdef ALU_SHARE_ARBITER_PRECHECK_EN
                        if ((g1 ? req1_opcode[2:1] : req0_opcode[2:1]) == 2'b11) m_state = RESP;
`endif
                    end
                    EXEC: m_state = RESP;
                    RESP: if (rsp_ready) begin
                        void'(sb.pop_front());
                        m_state = IDLE;
                    end
                    default: m_state = IDLE;
                endcase
            end
        end
    end

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_ops();
        req0_a      = BITS'($urandom);
        req0_b      = BITS'($urandom);
        req0_opcode = 3'($urandom_range(0, 5));
        req0_flags  = FLAGS_W'($urandom);
        req1_a      = BITS'($urandom);
        req1_b      = BITS'($urandom);
        req1_opcode = 3'($urandom_range(0, 5));
        req1_flags  = FLAGS_W'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_opcode, 0);
        check("rst_alu_flags", {alu_cin, alu_red_op_a, alu_red_op_b, alu_bypass_a, alu_bypass_b}, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_flags", {rsp_odd_parity, rsp_invalid}, 0);
        @(posedge clk); #1;

        // ---------------- contention: strict alternation ----------------
        rst = 1'b0;
        grant_log.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            @(posedge clk); #1;
        end
        idle(4);
        check("cont_ngrants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("cont_grant%0d", i), grant_log[i], i % 2);

        // ---------------- single command, req0 ADD 3+4 ----------------
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h4; req0_opcode = OP_ADD; req0_flags = '0;
        @(negedge clk);
        check("single_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_alu_a", alu_a, 4'h3);
        check("single_alu_b", alu_b, 4'h4);
        check("single_alu_op", alu_opcode, OP_ADD);
        check("single_rsp_early", rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 0);
        check("single_rsp_data", rsp_data, 5'b00111);
        idle(3);

        // ---------------- backpressure ----------------
        rand_ops();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_grant", req0_ready, 1);
        @(posedge clk); #1;
        idle(4);

        // ---------------- reset during EXEC ----------------
        req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'h2; req1_opcode = OP_XOR; req1_flags = '0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rand_ops();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("rx_rsp_valid", rsp_valid, 0);
        check("rx_alu_a", alu_a, 0);
        check("rx_tie_ready0", req0_ready, 1);
        check("rx_tie_ready1", req1_ready, 0);
        @(posedge clk); #1;
        idle(5);

        // ---------------- invalid opcode from req1 ----------------
        req0_valid = 1'b1; req0_a = 4'hA; req0_b = 4'h5; req0_opcode = OP_AND; req0_flags = '0;
        @(posedge clk); #1;
        idle(4);
        req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h9; req1_opcode = 3'b111; req1_flags = '0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
`ifdef ALU_SHARE_ARBITER_PRECHECK_EN
        check("inv_rsp_valid", rsp_valid, 1);
        check("inv_rsp_invalid", rsp_invalid, 1);
        check("inv_rsp_data", rsp_data, 0);
        check("inv_rsp_parity", rsp_odd_parity, 0);
        check("inv_alu_a_kept", alu_a, 4'hA);
        check("inv_alu_op_kept", alu_opcode, OP_AND);
`else
        check("inv_rsp_early", rsp_valid, 0);
        check("inv_alu_op", alu_opcode, 3'b111);
        @(posedge clk); #1;
        @(negedge clk);
        check("inv_rsp_valid", rsp_valid, 1);
        check("inv_rsp_invalid", rsp_invalid, 1);
        check("inv_rsp_id", rsp_id, 1);
`endif
        @(posedge clk); #1;
        idle(4);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire
